// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite OAM DMA engine: halts the CPU and copies one 256-byte page into primary OAM
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_halt,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_dma,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        parity;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [7:0]  oam_base;
    logic [7:0]  src_page;
    logic [7:0]  byte_latch;
    logic        wr_base;
    logic        wr_page;
    logic        last_write;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wr_base    = 1'b0;
        wr_page    = 1'b0;
        last_write = 1'b0;
        if (cpu_ce) begin
            case (state)
                S_IDLE: begin
                    wr_base = cpu_we && (cpu_addr == 16'h2003);
                    if (cpu_we && (cpu_addr == 16'h4014)) begin
                        wr_page   = 1'b1;
                        state_nxt = S_HALT;
                    end
                end
                // parity here types the cycle that this cpu_ce starts; reads must start on a get cycle
                S_HALT:  state_nxt = parity ? S_ALIGN : S_READ;
                S_ALIGN: state_nxt = S_READ;
                S_READ:  state_nxt = S_WRITE;
                S_WRITE: begin
                    cnt_nxt    = cnt + 8'd1;
                    last_write = (cnt == 8'hFF);
                    state_nxt  = last_write ? S_IDLE : S_READ;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            parity     <= 1'b0;
            cnt        <= 8'd0;
            oam_base   <= 8'd0;
            src_page   <= 8'd0;
            byte_latch <= 8'd0;
            dma_addr   <= 16'd0;
            oam_addr   <= 8'd0;
            dma_done   <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            if (cpu_ce) begin
                parity <= ~parity;
                state  <= state_nxt;
                if (wr_base) begin
                    oam_base <= cpu_wdata;
                end
                if (wr_page) begin
                    src_page <= cpu_wdata;
                    cnt      <= 8'd0;
                end else begin
                    cnt <= cnt_nxt;
                end
                // address registers only move on entry, so they hold their last value while idle
                if (state_nxt == S_READ) begin
                    dma_addr <= {src_page, cnt_nxt};
                end
                if (state == S_READ) begin
                    byte_latch <= mem_rdata;
                    oam_addr   <= oam_base + cnt;
                end
                if (last_write) begin
                    dma_done <= 1'b1;
                end
            end
        end
    end

    assign cpu_halt = (state != S_IDLE);
    assign dma_rd   = (state == S_READ);
    assign oam_dma  = (state == S_WRITE);
    assign oam_data = byte_latch;

endmodule
